// File: rtl/core_pkg.sv
// Shared core definitions: instruction class patterns, forwarding/hazard enums
// and the decoded register-usage record.
package core_pkg;

  // Class patterns for casez decode (RV32I base opcodes)
  localparam logic [31:0] I_ALL_LOADS = 32'b????????????_?????_???_?????_0000011;
  localparam logic [31:0] S_ALL       = 32'b???????_?????_?????_0??_?????_0100011;
  localparam logic [31:0] R_ALL       = 32'b0?00000_?????_?????_???_?????_0110011;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       rd_we;
    logic       rs1_use;
    logic       rs2_use;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_uses_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } ex_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } mem_rec_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Execute-stage hazard interface: instruction/memory status in, pipeline
// control and forwarding selects out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import core_pkg::*;

  logic [31:0]      instr_i;
  logic             valid_i;
  logic             mem_ready_i;
  logic             stall_o;
  logic             bubble_o;
  logic             hold_o;
  fwd_sel_e         fwd_rs1_sel_o;
  fwd_sel_e         fwd_rs2_sel_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output instr_i, valid_i, mem_ready_i,
    input  stall_o, bubble_o, hold_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, valid_i, mem_ready_i,
    output stall_o, bubble_o, hold_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
  );

endinterface

// File: rtl/instr_uses.sv
// Combinational register-usage decode of one instruction; index 0 and
// invalid slots never report a use.
module instr_uses
  import core_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output instr_uses_t uses
);

  logic wr;
  logic r1;
  logic r2;
  logic ld;

  always_comb begin
    wr = 1'b0;
    r1 = 1'b0;
    r2 = 1'b0;
    ld = 1'b0;
    casez (instr)
      I_ALL_LOADS: begin wr = 1'b1; r1 = 1'b1; ld = 1'b1; end
      S_ALL:       begin r1 = 1'b1; r2 = 1'b1; end
      R_ALL:       begin wr = 1'b1; r1 = 1'b1; r2 = 1'b1; end
      default:     ;
    endcase
  end

  always_comb begin
    uses         = '0;
    uses.rd      = instr[11:7];
    uses.rs1     = instr[19:15];
    uses.rs2     = instr[24:20];
    uses.rd_we   = valid && wr && (instr[11:7] != 5'd0);
    uses.rs1_use = valid && r1 && (instr[19:15] != 5'd0);
    uses.rs2_use = valid && r2 && (instr[24:20] != 5'd0);
    uses.is_load = valid && ld;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside the execute stage: forwarding selects, load-use
// bubble, memory-wait freeze and a saturating stall-cycle counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  instr_uses_t      uses;
  ex_rec_t          ex_rec_reg;
  ex_rec_t          ex_rec_next;
  mem_rec_t         mem_rec_reg;
  mem_rec_t         mem_rec_next;
  hz_state_e        state_reg;
  hz_state_e        state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic             stall;
  logic             bubble;
  logic             hold;
  logic [1:0]       rs_use;
  logic [1:0][4:0]  rs_idx;
  logic [1:0]       ex_hit;
  logic [1:0]       mem_hit;
  fwd_sel_e         fwd_sel [2];
  logic             load_use;
  logic             raw_hazard;

  instr_uses u_dec (
    .instr (hz.instr_i),
    .valid (hz.valid_i),
    .uses  (uses)
  );

  assign rs_use = {uses.rs2_use, uses.rs1_use};
  assign rs_idx = {uses.rs2, uses.rs1};

  // Youngest producer (EX/MEM) wins over MEM/WB
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rs
      assign ex_hit[gi]  = ex_rec_reg.valid && rs_use[gi] && (ex_rec_reg.rd == rs_idx[gi]);
      assign mem_hit[gi] = mem_rec_reg.valid && rs_use[gi] && (mem_rec_reg.rd == rs_idx[gi]);
      assign fwd_sel[gi] = !ENABLE_FWD ? FWD_NONE :
                           ex_hit[gi]  ? FWD_EX   :
                           mem_hit[gi] ? FWD_MEM  : FWD_NONE;
    end
  endgenerate

  assign load_use   = ex_rec_reg.is_load && (|ex_hit);
  assign raw_hazard = ENABLE_FWD ? load_use : ((|ex_hit) || (|mem_hit));

  // A memory wait dominates in every state; otherwise a RAW hazard bubbles.
  // LOAD_STALL only recurs without forwarding, while the producer sits in MEM/WB.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    case (state_reg)
      RUN, LOAD_STALL, MEM_WAIT: begin
        if (!hz.mem_ready_i) begin
          stall      = 1'b1;
          hold       = 1'b1;
          state_next = MEM_WAIT;
        end else if (raw_hazard) begin
          stall      = 1'b1;
          bubble     = 1'b1;
          state_next = LOAD_STALL;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    mem_rec_next = '{valid: ex_rec_reg.valid, rd: ex_rec_reg.rd};
    ex_rec_next  = bubble ? '0 : '{valid: uses.rd_we, rd: uses.rd, is_load: uses.is_load && uses.rd_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      ex_rec_reg  <= '0;
      mem_rec_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (!hold) begin
        mem_rec_reg <= mem_rec_next;
        ex_rec_reg  <= ex_rec_next;
      end
      if (stall && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign hz.stall_o       = stall;
  assign hz.bubble_o      = bubble;
  assign hz.hold_o        = hold;
  assign hz.fwd_rs1_sel_o = fwd_sel[0];
  assign hz.fwd_rs2_sel_o = fwd_sel[1];
  assign hz.stall_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a forwarding instance and a no-forwarding
// instance with a 3-bit counter for saturation.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hif ();
  hazard_ctrl_if #(.CNT_W(3))  nif ();

  hazard_ctrl #(.CNT_W(16), .ENABLE_FWD(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  hazard_ctrl #(.CNT_W(3), .ENABLE_FWD(1'b0)) u_dut_nofwd (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (nif)
  );

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
    return r_op(7'b0000000, 3'b000, rd, rs1, rs2);
  endfunction

  function automatic logic [31:0] lw_i(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] sw_i(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction

  // Drive one cycle of inputs, then wait to the sampling (falling) edge
  task automatic set_h(input logic [31:0] ins, input logic v, input logic r);
    hif.instr_i = ins; hif.valid_i = v; hif.mem_ready_i = r;
    @(negedge clk);
    $display("[%0t] fwd  instr=%h valid=%b rdy=%b -> stall=%b bubble=%b hold=%b sel=%0d/%0d cnt=%0d",
             $time, ins, v, r, hif.stall_o, hif.bubble_o, hif.hold_o,
             hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o, hif.stall_cnt_o);
  endtask

  task automatic set_n(input logic [31:0] ins, input logic v, input logic r);
    nif.instr_i = ins; nif.valid_i = v; nif.mem_ready_i = r;
    @(negedge clk);
    $display("[%0t] nfwd instr=%h valid=%b rdy=%b -> stall=%b bubble=%b hold=%b sel=%0d/%0d cnt=%0d",
             $time, ins, v, r, nif.stall_o, nif.bubble_o, nif.hold_o,
             nif.fwd_rs1_sel_o, nif.fwd_rs2_sel_o, nif.stall_cnt_o);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_h();
    for (int i = 0; i < 2; i++) begin set_h(NOP, 1'b1, 1'b1); adv(); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", hif.stall_o); end
    checks++; if (hif.bubble_o !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", hif.bubble_o); end
    checks++; if (hif.hold_o !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", hif.hold_o); end
    checks++; if (hif.fwd_rs1_sel_o !== FWD_NONE || hif.fwd_rs2_sel_o !== FWD_NONE) begin errors++;
      $display("FAIL rst_sel: got %0d/%0d want 0/0", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o); end
    checks++; if (hif.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", hif.stall_cnt_o); end
    rst_n = 1'b1;
    adv();
  endtask

  task automatic test_reset_mid_stall();
    set_h(lw_i(4, 1), 1'b1, 1'b1); adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b1 || hif.bubble_o !== 1'b1) begin errors++;
      $display("FAIL mid_lu: got stall=%b bubble=%b want 1/1", hif.stall_o, hif.bubble_o); end
    adv();
    checks++; if (hif.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL mid_cnt_pre: got %0d want 1", hif.stall_cnt_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (hif.stall_o !== 1'b0 || hif.bubble_o !== 1'b0 || hif.hold_o !== 1'b0) begin errors++;
      $display("FAIL mid_rst_out: got stall=%b bubble=%b hold=%b want 0/0/0", hif.stall_o, hif.bubble_o, hif.hold_o); end
    checks++; if (hif.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", hif.stall_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b0 || hif.fwd_rs1_sel_o !== FWD_NONE) begin errors++;
      $display("FAIL mid_after: got stall=%b sel1=%0d want 0/0", hif.stall_o, hif.fwd_rs1_sel_o); end
    adv(); flush_h();
  endtask

  task automatic test_fwd_ex();
    set_h(add_i(5, 1, 2), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_NONE || hif.stall_o !== 1'b0) begin errors++;
      $display("FAIL ex_first: got sel1=%0d stall=%b want 0/0", hif.fwd_rs1_sel_o, hif.stall_o); end
    adv();
    set_h(r_op(7'b0100000, 3'b000, 6, 5, 3), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_EX || hif.fwd_rs2_sel_o !== FWD_NONE) begin errors++;
      $display("FAIL ex_sel: got %0d/%0d want 1/0", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o); end
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL ex_stall: got %b want 0", hif.stall_o); end
    adv(); flush_h();
  endtask

  task automatic test_fwd_mem();
    set_h(add_i(5, 1, 2), 1'b1, 1'b1); adv();
    set_h(NOP, 1'b1, 1'b1); adv();
    set_h(r_op(7'b0000000, 3'b110, 7, 5, 5), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_MEM || hif.fwd_rs2_sel_o !== FWD_MEM) begin errors++;
      $display("FAIL mem_sel: got %0d/%0d want 2/2", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o); end
    adv(); flush_h();
  endtask

  task automatic test_youngest();
    set_h(add_i(5, 1, 2), 1'b1, 1'b1); adv();
    set_h(add_i(5, 3, 4), 1'b1, 1'b1); adv();
    set_h(r_op(7'b0000000, 3'b100, 8, 5, 6), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_EX || hif.fwd_rs2_sel_o !== FWD_NONE) begin errors++;
      $display("FAIL young_sel: got %0d/%0d want 1/0", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o); end
    adv(); flush_h();
  endtask

  task automatic test_load_use();
    set_h(lw_i(4, 1), 1'b1, 1'b1); adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b1 || hif.bubble_o !== 1'b1 || hif.hold_o !== 1'b0) begin errors++;
      $display("FAIL lu_stall: got stall=%b bubble=%b hold=%b want 1/1/0", hif.stall_o, hif.bubble_o, hif.hold_o); end
    adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b0 || hif.bubble_o !== 1'b0) begin errors++;
      $display("FAIL lu_second: got stall=%b bubble=%b want 0/0", hif.stall_o, hif.bubble_o); end
    checks++; if (hif.fwd_rs1_sel_o !== FWD_MEM) begin errors++; $display("FAIL lu_sel: got %0d want 2", hif.fwd_rs1_sel_o); end
    checks++; if (hif.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", hif.stall_cnt_o); end
    adv(); flush_h();
  endtask

  task automatic test_mem_wait();
    set_h(add_i(10, 1, 2), 1'b1, 1'b1); adv();
    for (int k = 0; k < 3; k++) begin
      set_h(sw_i(10, 1), 1'b1, 1'b0);
      checks++; if (hif.stall_o !== 1'b1 || hif.hold_o !== 1'b1 || hif.bubble_o !== 1'b0) begin errors++;
        $display("FAIL mw_ctl[%0d]: got stall=%b hold=%b bubble=%b want 1/1/0", k, hif.stall_o, hif.hold_o, hif.bubble_o); end
      checks++; if (hif.fwd_rs2_sel_o !== FWD_EX) begin errors++; $display("FAIL mw_sel[%0d]: got %0d want 1", k, hif.fwd_rs2_sel_o); end
      adv();
    end
    set_h(sw_i(10, 1), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b0 || hif.hold_o !== 1'b0 || hif.fwd_rs2_sel_o !== FWD_EX) begin errors++;
      $display("FAIL mw_release: got stall=%b hold=%b sel2=%0d want 0/0/1", hif.stall_o, hif.hold_o, hif.fwd_rs2_sel_o); end
    checks++; if (hif.stall_cnt_o !== 16'd4) begin errors++; $display("FAIL mw_cnt: got %0d want 4", hif.stall_cnt_o); end
    adv();
    set_h(r_op(7'b0000000, 3'b110, 7, 10, 10), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_MEM || hif.fwd_rs2_sel_o !== FWD_MEM) begin errors++;
      $display("FAIL mw_after: got %0d/%0d want 2/2", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o); end
    adv(); flush_h();
  endtask

  task automatic test_load_use_in_wait();
    set_h(lw_i(4, 1), 1'b1, 1'b1); adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b0);
    checks++; if (hif.stall_o !== 1'b1 || hif.hold_o !== 1'b1 || hif.bubble_o !== 1'b0) begin errors++;
      $display("FAIL luw_wait: got stall=%b hold=%b bubble=%b want 1/1/0", hif.stall_o, hif.hold_o, hif.bubble_o); end
    adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b1 || hif.bubble_o !== 1'b1 || hif.hold_o !== 1'b0) begin errors++;
      $display("FAIL luw_bubble: got stall=%b bubble=%b hold=%b want 1/1/0", hif.stall_o, hif.bubble_o, hif.hold_o); end
    adv();
    set_h(add_i(9, 4, 2), 1'b1, 1'b1);
    checks++; if (hif.stall_o !== 1'b0 || hif.fwd_rs1_sel_o !== FWD_MEM) begin errors++;
      $display("FAIL luw_fwd: got stall=%b sel1=%0d want 0/2", hif.stall_o, hif.fwd_rs1_sel_o); end
    checks++; if (hif.stall_cnt_o !== 16'd6) begin errors++; $display("FAIL luw_cnt: got %0d want 6", hif.stall_cnt_o); end
    adv(); flush_h();
  endtask

  task automatic test_x0();
    set_h(add_i(0, 1, 2), 1'b1, 1'b1); adv();
    set_h(add_i(11, 0, 0), 1'b1, 1'b1);
    checks++; if (hif.fwd_rs1_sel_o !== FWD_NONE || hif.fwd_rs2_sel_o !== FWD_NONE || hif.stall_o !== 1'b0) begin errors++;
      $display("FAIL x0_sel: got %0d/%0d stall=%b want 0/0/0", hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o, hif.stall_o); end
    adv(); flush_h();
  endtask

  task automatic test_no_fwd();
    set_n(add_i(5, 1, 2), 1'b1, 1'b1);
    checks++; if (nif.stall_o !== 1'b0) begin errors++; $display("FAIL nf_first: got %b want 0", nif.stall_o); end
    adv();
    for (int k = 0; k < 2; k++) begin
      set_n(add_i(6, 5, 3), 1'b1, 1'b1);
      checks++; if (nif.stall_o !== 1'b1 || nif.bubble_o !== 1'b1 || nif.fwd_rs1_sel_o !== FWD_NONE) begin errors++;
        $display("FAIL nf_stall[%0d]: got stall=%b bubble=%b sel1=%0d want 1/1/0", k, nif.stall_o, nif.bubble_o, nif.fwd_rs1_sel_o); end
      adv();
    end
    set_n(add_i(6, 5, 3), 1'b1, 1'b1);
    checks++; if (nif.stall_o !== 1'b0 || nif.bubble_o !== 1'b0 || nif.fwd_rs1_sel_o !== FWD_NONE) begin errors++;
      $display("FAIL nf_release: got stall=%b bubble=%b sel1=%0d want 0/0/0", nif.stall_o, nif.bubble_o, nif.fwd_rs1_sel_o); end
    checks++; if (nif.stall_cnt_o !== 3'd2) begin errors++; $display("FAIL nf_cnt: got %0d want 2", nif.stall_cnt_o); end
    adv();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 7; k++) begin set_n(NOP, 1'b0, 1'b0); adv(); end
    set_n(NOP, 1'b0, 1'b0);
    checks++; if (nif.stall_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_cnt: got %0d want 7", nif.stall_cnt_o); end
    adv();
    set_n(NOP, 1'b0, 1'b1);
    checks++; if (nif.stall_cnt_o !== 3'd7 || nif.stall_o !== 1'b0) begin errors++;
      $display("FAIL sat_hold: got cnt=%0d stall=%b want 7/0", nif.stall_cnt_o, nif.stall_o); end
    adv();
  endtask

  initial begin
    hif.instr_i = NOP; hif.valid_i = 1'b0; hif.mem_ready_i = 1'b1;
    nif.instr_i = NOP; nif.valid_i = 1'b0; nif.mem_ready_i = 1'b1;
    test_reset();
    test_reset_mid_stall();
    test_fwd_ex();
    test_fwd_mem();
    test_youngest();
    test_load_use();
    test_mem_wait();
    test_load_use_in_wait();
    test_x0();
    hif.valid_i = 1'b0;
    test_no_fwd();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
